// File: rtl/uart_msg_tx_drain.sv
// Streams msg_len bytes from the message buffer read port to a valid/ready UART byte sink, then acks.
// Optional UART_MSG_NUL_STOP_EN: a NUL read from the buffer ends the message early without being sent.
module uart_msg_tx_drain #(
  parameter int WIDTH = 8,
  parameter int LEN   = 256,
  localparam int AW   = $clog2(LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_valid,
  input  logic [AW-1:0]    msg_len,
  output logic             msg_ack,
  output logic             busy,
  output logic [AW-1:0]    rd_addr,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SEND, S_ACK, S_HOLD
  } state_t;

  state_t           r_state, w_next;
  logic [AW-1:0]    r_len, r_cnt, r_rd_addr;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_tx_valid;

  logic [AW-1:0] w_len_clamped, w_cnt_inc;
  logic          w_hs, w_nul;

  assign w_len_clamped = (msg_len > AW'(LEN)) ? AW'(LEN) : msg_len;
  assign w_cnt_inc     = r_cnt + AW'(1);
  assign w_hs          = r_tx_valid & tx_ready;

`ifdef UART_MSG_NUL_STOP_EN
  assign w_nul = (rd_data == '0);
`else
  assign w_nul = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (msg_valid) w_next = (w_len_clamped == '0) ? S_ACK : S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = w_nul ? S_ACK : S_SEND;
      S_SEND:  if (w_hs) w_next = (w_cnt_inc == r_len) ? S_ACK : S_FETCH;
      S_ACK:   w_next = S_HOLD;
      S_HOLD:  if (!msg_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // rd_addr is preloaded on the way into FETCH so the read strobe and address line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_rd_addr  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (msg_valid) begin
          r_len <= w_len_clamped;
          r_cnt <= '0;
          if (w_len_clamped != '0) r_rd_addr <= '0;
        end
        S_WAIT: if (!w_nul) begin
          r_tx_data  <= rd_data;
          r_tx_valid <= 1'b1;
        end
        S_SEND: if (w_hs) begin
          r_tx_valid <= 1'b0;
          r_cnt      <= w_cnt_inc;
          if (w_cnt_inc != r_len) r_rd_addr <= w_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign rd_en    = (r_state == S_FETCH);
  assign rd_addr  = r_rd_addr;
  assign msg_ack  = (r_state == S_ACK);
  assign busy     = (r_state != S_IDLE);
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

// File: doc/uart_msg_tx_drain.md
Name: uart_msg_tx_drain

Overview:
- Downstream neighbour of the message-composing core.
- When the core raises msg_valid/msg_len, this block reads msg_len bytes from the shared message buffer's read port (addresses 0..msg_len-1) and streams them to the UART transmitter over a valid/ready byte interface.
- When the last byte is accepted, it pulses msg_ack so the composer can return to idle.
- Sits between the message buffer/core and the uart_tx serializer.

Parameters:
WIDTH, 8, byte width of the buffer data and the transmit data.
LEN, 256, buffer depth in entries. AW = (number of bits needed to represent LEN-1) + 1, i.e. 9 for LEN=256, to match the core's address and length width.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
msg_valid  input  1  level; a message of msg_len bytes is ready in the buffer.
msg_len  input  AW  byte count; sampled in IDLE when msg_valid=1.
msg_ack  output  1  one-cycle pulse; message fully handed to the transmitter.
busy  output  1  high in any state other than IDLE.
rd_addr  output  AW  buffer read address.
rd_en  output  1  buffer read strobe.
rd_data  input  WIDTH  buffer read data, valid exactly 1 cycle after rd_en.
tx_data  output  WIDTH  byte to the UART transmitter.
tx_valid  output  1  tx_data valid; held until accepted.
tx_ready  input  1  transmitter can accept; transfer occurs when tx_valid & tx_ready.

Behaviour:
- Reset values: msg_ack=0, busy=0, rd_addr=0, rd_en=0, tx_data=0, tx_valid=0. Internal state = IDLE, byte counter = 0, length register = 0.
- Reset mid-message aborts immediately: tx_valid drops the next cycle, no msg_ack is issued, and the remaining bytes are discarded.
- FSM states: IDLE, FETCH, WAIT, SEND, ACK, HOLD.
- IDLE: if msg_valid=1, latch len <= msg_len and cnt <= 0.
  - If msg_len==0, go to ACK (no reads, no tx).
  - Otherwise go to FETCH.
- FETCH: drive rd_addr=cnt and rd_en=1 for exactly one cycle, then go to WAIT.
- WAIT: capture tx_data <= rd_data, set tx_valid=1, go to SEND.
- SEND: hold tx_data and tx_valid stable until tx_ready=1. On the handshake cycle:
  - tx_valid <= 0 and cnt <= cnt+1.
  - If cnt+1 == len, go to ACK; else go to FETCH.
  - tx_ready may already be high on the first SEND cycle, giving 1-cycle acceptance.
- Throughput: minimum 3 cycles per byte (FETCH, WAIT, SEND) when tx_ready is always high. First tx_valid appears 2 cycles after msg_valid is sampled.
- ACK: msg_ack=1 for exactly one cycle, then go to HOLD.
- HOLD: wait for msg_valid=0, then go to IDLE. This prevents the same message being re-sent if the producer lowers msg_valid late.
- Addressing:
  - rd_addr is only meaningful when rd_en=1; it holds its last value otherwise.
  - Counter and length are AW bits wide; cnt never exceeds len.
  - msg_len values >= LEN are clamped to LEN.
- Stability: msg_len changes while busy are ignored. tx_data never changes while tx_valid=1 && tx_ready=0.

Optional Feature:
- Macro UART_MSG_NUL_STOP_EN.
- Defined: in WAIT, if rd_data == 0, no byte is presented (tx_valid stays 0) and the FSM goes straight to ACK. A NUL terminates the message early and is not transmitted.
- Undefined: NUL bytes are transmitted like any other byte, and only msg_len ends the message.

Test Plan:
- Normal message: buffer holds " 0~99\n\r", msg_len=7, tx_ready=1 -> tx bytes 0x20,0x30,0x7E,0x39,0x39,0x0A,0x0D in order, one msg_ack pulse, then busy=0 after msg_valid drops.
- Back-pressure: msg_len=3, tx_ready low for 5 cycles per byte -> tx_data/tx_valid stable while stalled, exactly 3 handshakes, no duplicates or skips.
- Empty message: msg_len=0 -> no rd_en, no tx_valid, msg_ack 1 cycle after sampling.
- Sticky msg_valid: msg_valid held high for 20 cycles after msg_ack -> block stays in HOLD (busy=1), no second transmission; lowering msg_valid returns it to IDLE.
- Reset mid-message: assert rst while the 3rd of 7 bytes is in SEND -> all outputs at reset values the next cycle; new msg_len=2 afterwards sends bytes from addresses 0,1.
- With UART_MSG_NUL_STOP_EN: buffer "AB\0CD", msg_len=5 -> only 0x41,0x42 sent, then msg_ack. Without the macro, all 5 bytes are sent, including 0x00.
